// File: rtl/udp_seq_header_insert.sv
// udp_seq_header_insert: prepends a big-endian sequence header to each
// outgoing payload packet, sourced from a preloadable per-packet counter.
module udp_seq_header_insert #(
    parameter int DSIZE     = 8,
    parameter int FIELD_LEN = 8,
    parameter logic [DSIZE*FIELD_LEN-1:0] SEQ_INIT = '0
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       seq_load,
    input  logic [DSIZE*FIELD_LEN-1:0] seq_value,
    input  logic [DSIZE-1:0]           in_tdata,
    input  logic                       in_tvalid,
    input  logic                       in_tlast,
    output logic                       in_tready,
    output logic [DSIZE-1:0]           out_tdata,
    output logic                       out_tvalid,
    output logic                       out_tlast,
    input  logic                       out_tready,
    output logic [DSIZE*FIELD_LEN-1:0] cur_seq,
    output logic                       busy
);

    localparam int W  = DSIZE * FIELD_LEN;
    localparam int IW = (FIELD_LEN > 1) ? $clog2(FIELD_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FIELD_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        BODY
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  hdr_q, hdr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  seq_q, seq_d;
    logic          pend_q, pend_d;
    logic          busy_q;
    logic          eop;
    logic          inc;

    // Next-state, header shifting and stream outputs.
    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        idx_d      = idx_q;
        eop        = 1'b0;
        in_tready  = 1'b0;
        out_tdata  = '0;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_tvalid) begin
                    hdr_d   = seq_q;
                    idx_d   = '0;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                out_tvalid = 1'b1;
                out_tdata  = hdr_q[W-1 -: DSIZE];
                if (out_tready) begin
                    hdr_d = hdr_q << DSIZE;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = BODY;
                    end
                end
            end
            BODY: begin
                out_tdata  = in_tdata;
                out_tvalid = in_tvalid;
                out_tlast  = in_tlast;
                in_tready  = out_tready;
                if (in_tvalid && out_tready && in_tlast) begin
                    eop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A load seen while a packet is in flight names the next packet's
    // sequence, so it suppresses that packet's end-of-packet increment.
    always_comb begin
        pend_d = pend_q;
        if (seq_load) begin
            pend_d = 1'b1;
        end
        if (state_d == IDLE) begin
            pend_d = 1'b0;
        end
        inc = eop && !pend_q && !seq_load;
        if (seq_load) begin
            seq_d = seq_value;
        end else if (inc) begin
            seq_d = seq_q + 1'b1;
        end else begin
            seq_d = seq_q;
        end
    end

    // State, header and counter registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            idx_q   <= '0;
            seq_q   <= SEQ_INIT;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            pend_q  <= pend_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign cur_seq = seq_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_udp_seq_header_insert.sv
// tb_udp_seq_header_insert: directed bench with a packet-level model
// (expected word queue + sequence counter) and a per-cycle monitor.
module tb_udp_seq_header_insert;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        seq_load = 1'b0;
    logic [63:0] seq_value = '0;
    logic [7:0]  in_tdata = '0;
    logic        in_tvalid = 1'b0;
    logic        in_tlast = 1'b0;
    logic        in_tready;
    logic [7:0]  out_tdata;
    logic        out_tvalid;
    logic        out_tlast;
    logic        out_tready = 1'b1;
    logic [63:0] cur_seq;
    logic        busy;

    int checks = 0;
    int failures = 0;
    bit bp = 1'b0;

    logic [8:0]  exp_q[$];
    logic [63:0] hdr_log[$];
    logic [63:0] model_seq = '0;
    logic [7:0]  pk[$];
    int          cyc;

    udp_seq_header_insert #(
        .DSIZE(8),
        .FIELD_LEN(8),
        .SEQ_INIT(64'h0)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
        .seq_load(seq_load),
        .seq_value(seq_value),
        .in_tdata(in_tdata),
        .in_tvalid(in_tvalid),
        .in_tlast(in_tlast),
        .in_tready(in_tready),
        .out_tdata(out_tdata),
        .out_tvalid(out_tvalid),
        .out_tlast(out_tlast),
        .out_tready(out_tready),
        .cur_seq(cur_seq),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clock) begin
        #1;
        out_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: every output handshake must match the model queue, and a
    // stalled word must stay valid and unchanged.
    bit          stall = 1'b0;
    logic [7:0]  held;
    logic [63:0] acc;
    int          pos = 0;
    always @(negedge clock) begin
        logic [8:0] e;
        if (!rst_n) begin
            stall = 1'b0;
            pos = 0;
        end else begin
            if (stall) begin
                chk("hold_valid", 64'(out_tvalid), 64'd1);
                chk("hold_data", 64'(out_tdata), 64'(held));
            end
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(out_tdata), 64'hx);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_tdata", 64'(out_tdata), 64'(e[8:1]));
                    chk("out_tlast", 64'(out_tlast), 64'(e[0]));
                end
                if (pos < 8) acc = {acc[55:0], out_tdata};
                if (pos == 7) hdr_log.push_back(acc);
                pos = out_tlast ? 0 : pos + 1;
            end
            stall = out_tvalid && !out_tready;
            held = out_tdata;
        end
    end

    task automatic send_pkt(input logic [7:0] d[$], input int load_idx,
                            input logic [63:0] load_val, output int cycles);
        int i = 0;
        int n = d.size();
        logic hs;
        for (int k = 0; k < 8; k++) exp_q.push_back({model_seq[63-8*k -: 8], 1'b0});
        for (int k = 0; k < n; k++) exp_q.push_back({d[k], k == n - 1});
        @(posedge clock);
        #1;
        in_tvalid = 1'b1;
        in_tdata = d[0];
        in_tlast = (n == 1);
        cycles = 0;
        while (i < n && cycles < 2000) begin
            @(negedge clock);
            hs = in_tready && in_tvalid;
            if (hs && i == load_idx) begin
                seq_load = 1'b1;
                seq_value = load_val;
            end
            @(posedge clock);
            #1;
            seq_load = 1'b0;
            cycles++;
            if (hs) begin
                i++;
                if (i < n) begin
                    in_tdata = d[i];
                    in_tlast = (i == n - 1);
                end
            end
        end
        in_tvalid = 1'b0;
        in_tlast = 1'b0;
        if (i < n) chk("send_timeout", 64'(i), 64'(n));
        model_seq = (load_idx >= 0) ? load_val : model_seq + 1;
        chk("cur_seq_model", cur_seq, model_seq);
    endtask

    task automatic idle_load(input logic [63:0] v);
        @(posedge clock);
        #1;
        seq_load = 1'b1;
        seq_value = v;
        @(posedge clock);
        #1;
        seq_load = 1'b0;
        model_seq = v;
    endtask

    task automatic rand_pkt(input int n);
        pk.delete();
        for (int k = 0; k < n; k++) pk.push_back(8'($urandom));
    endtask

    initial begin
        #2;
        chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("rst_out_tlast", 64'(out_tlast), 64'd0);
        chk("rst_out_tdata", 64'(out_tdata), 64'd0);
        chk("rst_in_tready", 64'(in_tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cur_seq", cur_seq, 64'd0);
        @(negedge clock);
        rst_n = 1'b1;

        pk = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_pkt(pk, -1, '0, cyc);
        chk("latency_4B", 64'(cyc), 64'd13);
        chk("hdr_first", hdr_log[hdr_log.size()-1], 64'd0);
        chk("cur_seq_1", cur_seq, 64'd1);

        idle_load(64'h0102030405060708);
        pk = '{8'h55};
        send_pkt(pk, -1, '0, cyc);
        chk("hdr_preload", hdr_log[hdr_log.size()-1], 64'h0102030405060708);
        chk("cur_seq_pre", cur_seq, 64'h0102030405060709);

        @(negedge clock);
        rst_n = 1'b0;
        exp_q.delete();
        model_seq = '0;
        @(negedge clock);
        rst_n = 1'b1;
        bp = 1'b1;
        rand_pkt(1);
        send_pkt(pk, -1, '0, cyc);
        chk("bp_hdr0", hdr_log[hdr_log.size()-1], 64'd0);
        rand_pkt(7);
        send_pkt(pk, -1, '0, cyc);
        chk("bp_hdr1", hdr_log[hdr_log.size()-1], 64'd1);
        rand_pkt(64);
        send_pkt(pk, -1, '0, cyc);
        chk("bp_hdr2", hdr_log[hdr_log.size()-1], 64'd2);
        repeat (2) @(posedge clock);
        bp = 1'b0;
        repeat (2) @(posedge clock);

        idle_load(64'hFFFF_FFFF_FFFF_FFFF);
        rand_pkt(2);
        send_pkt(pk, -1, '0, cyc);
        chk("hdr_ffff", hdr_log[hdr_log.size()-1], 64'hFFFF_FFFF_FFFF_FFFF);
        rand_pkt(2);
        send_pkt(pk, -1, '0, cyc);
        chk("hdr_wrap", hdr_log[hdr_log.size()-1], 64'd0);

        rand_pkt(3);
        send_pkt(pk, 2, 64'h10, cyc);
        chk("collision", cur_seq, 64'h10);

        idle_load(64'h5);
        rand_pkt(4);
        send_pkt(pk, 1, 64'h20, cyc);
        chk("midload_cur", hdr_log[hdr_log.size()-1], 64'h5);
        rand_pkt(1);
        send_pkt(pk, -1, '0, cyc);
        chk("midload_next", hdr_log[hdr_log.size()-1], 64'h20);

        for (int k = 0; k < 8; k++) exp_q.push_back({model_seq[63-8*k -: 8], 1'b0});
        @(posedge clock);
        #1;
        in_tvalid = 1'b1;
        in_tdata = 8'h77;
        in_tlast = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 6; k++) @(negedge clock);
        chk("reach_hdr3", 64'(exp_q.size()), 64'd6);
        @(posedge clock);
        #2;
        chk("pre_rst_valid", 64'(out_tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_tvalid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_seq", cur_seq, 64'd0);
        exp_q.delete();
        in_tvalid = 1'b0;
        in_tlast = 1'b0;
        model_seq = '0;
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        rand_pkt(2);
        send_pkt(pk, -1, '0, cyc);
        chk("post_rst_hdr", hdr_log[hdr_log.size()-1], 64'd0);
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
